// File: rtl/mem_access.sv
// mem_access: MIPS memory-access stage. Runs a req/ack transaction on the
// data-RAM port for loads and stores, handles lane select, extension,
// byte enables and alignment, and feeds the MEM/WB register.
// i_rst_n is the asynchronous active-low RST input.
module mem_access (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_mem_alu_op,
  input  logic [31:0] i_mem_sdata,
  input  logic [31:0] i_mem_lsaddr,
  input  logic [31:0] i_mem_wdata,
  input  logic [4:0]  i_mem_waddr,
  input  logic        i_mem_wen,
  input  logic [31:0] i_mem_hi,
  input  logic [31:0] i_mem_lo,
  input  logic        i_mem_wen_hilo,
  input  logic        i_stall_mem,
  output logic        o_stall_req,
  output logic        o_addr_err,
  output logic        o_dram_req,
  output logic        o_dram_we,
  output logic [3:0]  o_dram_be,
  output logic [31:0] o_dram_addr,
  output logic [31:0] o_dram_wdata,
  input  logic        i_dram_ack,
  input  logic [31:0] i_dram_rdata,
  output logic [31:0] o_wb_wdata,
  output logic [4:0]  o_wb_waddr,
  output logic        o_wb_wen,
  output logic [31:0] o_wb_hi,
  output logic [31:0] o_wb_lo,
  output logic        o_wb_wen_hilo
);

  // Memory opcodes from defines.vh
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      r_state;
  logic        r_dram_req;
  logic        r_dram_we;
  logic [3:0]  r_dram_be;
  logic [31:0] r_dram_addr;
  logic [31:0] r_dram_wdata;
  logic [31:0] r_rdata;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_signed;
  size_t       w_size;
  logic        w_misaligned;
  logic        w_is_mem;
  logic        w_go;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_lane_b;
  logic [15:0] w_lane_h;
  logic [31:0] w_load_data;

  // Decode the operation into kind, access size and signedness.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_signed   = 1'b0;
    w_size     = SZ_W;
    case (i_mem_alu_op)
      EXE_LB_OP:  begin w_is_load  = 1'b1; w_size = SZ_B; w_signed = 1'b1; end
      EXE_LBU_OP: begin w_is_load  = 1'b1; w_size = SZ_B; end
      EXE_LH_OP:  begin w_is_load  = 1'b1; w_size = SZ_H; w_signed = 1'b1; end
      EXE_LHU_OP: begin w_is_load  = 1'b1; w_size = SZ_H; end
      EXE_LW_OP:  begin w_is_load  = 1'b1; w_size = SZ_W; end
      EXE_SB_OP:  begin w_is_store = 1'b1; w_size = SZ_B; end
      EXE_SH_OP:  begin w_is_store = 1'b1; w_size = SZ_H; end
      EXE_SW_OP:  begin w_is_store = 1'b1; w_size = SZ_W; end
      default:    ;
    endcase
  end

  assign w_is_mem     = w_is_load | w_is_store;
  assign w_misaligned = ((w_size == SZ_H) && i_mem_lsaddr[0]) ||
                        ((w_size == SZ_W) && (i_mem_lsaddr[1:0] != 2'b00));
  assign w_go         = w_is_mem & ~w_misaligned;

  // Byte enables and lane-replicated store data for the access size.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_mem_sdata;
    case (w_size)
      SZ_B: begin
        w_be    = 4'b0001 << i_mem_lsaddr[1:0];
        w_wdata = {4{i_mem_sdata[7:0]}};
      end
      SZ_H: begin
        w_be    = i_mem_lsaddr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_mem_sdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Transaction FSM: IDLE issues, REQ waits for ack, DONE holds until released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_dram_req   <= 1'b0;
      r_dram_we    <= 1'b0;
      r_dram_be    <= 4'b0000;
      r_dram_addr  <= 32'h0;
      r_dram_wdata <= 32'h0;
      r_rdata      <= 32'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_dram_req   <= 1'b1;
            r_dram_we    <= w_is_store;
            r_dram_be    <= w_be;
            r_dram_addr  <= {i_mem_lsaddr[31:2], 2'b00};
            r_dram_wdata <= w_wdata;
            r_state      <= REQ;
          end
        end
        REQ: begin
          if (i_dram_ack) begin
            r_rdata    <= i_dram_rdata;
            r_dram_req <= 1'b0;
            r_dram_we  <= 1'b0;
            r_dram_be  <= 4'b0000;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (!i_stall_mem) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Select the addressed lane of the captured read word and extend it.
  always_comb begin
    case (i_mem_lsaddr[1:0])
      2'd0:    w_lane_b = r_rdata[7:0];
      2'd1:    w_lane_b = r_rdata[15:8];
      2'd2:    w_lane_b = r_rdata[23:16];
      default: w_lane_b = r_rdata[31:24];
    endcase
    w_lane_h = i_mem_lsaddr[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (w_size)
      SZ_B:    w_load_data = {{24{w_signed & w_lane_b[7]}}, w_lane_b};
      SZ_H:    w_load_data = {{16{w_signed & w_lane_h[15]}}, w_lane_h};
      default: w_load_data = r_rdata;
    endcase
  end

  // Write-back selection: loads only write once their data is in DONE.
  always_comb begin
    o_wb_wdata = i_mem_wdata;
    o_wb_wen   = i_mem_wen;
    if (w_is_load) begin
      o_wb_wen = (r_state == DONE) ? i_mem_wen : 1'b0;
      if (r_state == DONE) o_wb_wdata = w_load_data;
    end
    if (w_is_mem && w_misaligned) o_wb_wen = 1'b0;
  end

  assign o_stall_req   = ((r_state == IDLE) && w_go) || (r_state == REQ);
  assign o_addr_err    = w_is_mem & w_misaligned;
  assign o_dram_req    = r_dram_req;
  assign o_dram_we     = r_dram_we;
  assign o_dram_be     = r_dram_be;
  assign o_dram_addr   = r_dram_addr;
  assign o_dram_wdata  = r_dram_wdata;
  assign o_wb_waddr    = i_mem_waddr;
  assign o_wb_hi       = i_mem_hi;
  assign o_wb_lo       = i_mem_lo;
  assign o_wb_wen_hilo = i_mem_wen_hilo;

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage MIPS pipeline: consumes the fields registered by the EX/MEM pipeline register, runs a request/acknowledge transaction on the data-RAM port for load and store operations, and presents write-back results to the MEM/WB register. It raises a stall request while a transaction is outstanding. It also performs byte/halfword lane selection, sign/zero extension, store byte-enable generation and alignment checking.

## Interface
- No parameters. Widths come from `defines.vh`: `REG_DATA_BUS` is 32 bits, `REG_ADDR_BUS` is 5 bits, `ALU_OP_BUS` is 8 bits.
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  asynchronous, active-low reset
- MEM_ALU_OP  in  ALU_OP_BUS  operation; `EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP` are memory ops, all others are pass-through
- MEM_SDATA  in  32  store data
- MEM_LSADDR  in  32  load/store byte address
- MEM_WDATA, MEM_WADDR, MEM_WEN  in  32/5/1  register write-back fields from EX
- MEM_HI, MEM_LO, MEM_WEN_HILO  in  32/32/1  HI/LO write-back fields
- STALL_MEM  in  1  1 = the MEM stage is held this cycle by the pipeline controller
- STALL_REQ  out  1  1 = MEM requests a pipeline stall
- ADDR_ERR  out  1  misaligned access detected this cycle
- DRAM_REQ, DRAM_WE  out  1/1  request valid; write enable
- DRAM_BE  out  4  byte enables (bit i enables bits 8i+7:8i)
- DRAM_ADDR, DRAM_WDATA  out  32/32  word address (bits 1:0 forced to 0); write data
- DRAM_ACK  in  1  RAM completed the request this cycle
- DRAM_RDATA  in  32  read data; valid when DRAM_ACK=1
- WB_WDATA, WB_WADDR, WB_WEN  out  32/5/1  outputs to the MEM/WB register
- WB_HI, WB_LO, WB_WEN_HILO  out  32/32/1  outputs to the MEM/WB register

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**
  - On an aligned memory op: register the DRAM_* fields and go to REQ.
  - On a misaligned memory op: stay in IDLE, assert ADDR_ERR, force WB_WEN=0, issue no request and raise no stall.
- **REQ**
  - DRAM_REQ=1; all DRAM_* outputs are held stable.
  - When DRAM_ACK=1: latch DRAM_RDATA into rdata_q, clear DRAM_REQ/WE/BE and go to DONE.
- **DONE**
  - Stay in DONE while STALL_MEM=1; go to IDLE when STALL_MEM=0.
  - This prevents re-issuing the same held instruction.
- **STALL_REQ** (combinational) = (IDLE and aligned memory op) or REQ. It is 0 in DONE.
- **Alignment rules**
  - LH/LHU/SH require LSADDR[0]=0.
  - LW/SW require LSADDR[1:0]=0.
  - Byte ops are always aligned.
- **Byte enables and write data**, with o=LSADDR[1:0], little-endian:
  - SB/LB/LBU: BE = 1<<o; write data = byte replicated ×4.
  - SH/LH/LHU: BE = o[1] ? 1100 : 0011; write data = halfword replicated ×2.
  - SW/LW: BE = 1111.
  - DRAM_WE=1 only for stores.
- **Load data, in DONE**
  - The selected lane of rdata_q is extended: LB/LH sign-extend, LBU/LHU zero-extend, LW uses the full word.
  - The result drives WB_WDATA.
- **WB_WEN**
  - For loads: WB_WEN = MEM_WEN only in DONE, otherwise 0.
  - For non-loads: WB_WDATA = MEM_WDATA and WB_WEN = MEM_WEN.
- **Pass-through:** WB_WADDR, WB_HI, WB_LO and WB_WEN_HILO always pass through their MEM_* inputs.
- **Ignored ACK:** DRAM_ACK in IDLE or DONE is ignored.
- **Reset**
  - Asserting RST at any point forces IDLE.
  - DRAM_REQ, DRAM_WE, DRAM_BE, DRAM_ADDR, DRAM_WDATA and rdata_q all go to 0.
  - An outstanding transaction is abandoned; a late ACK after reset is ignored.
  - Combinational outputs follow the inputs; with the NOP op driven by the reset EX/MEM register, STALL_REQ=0 and WB_WEN=0.

## Timing
- **Zero-wait RAM:** op appears at cycle 0 (IDLE, STALL_REQ=1); cycle 1 is REQ with ACK; cycle 2 is DONE (STALL_REQ=0, load data on WB_WDATA). Minimum memory-op occupancy is 3 cycles.
- **Wait states:** each cycle of DRAM_ACK=0 in REQ adds one cycle.
- **Request deassertion:** DRAM_REQ deasserts on the edge after the ACK cycle.
- **Non-memory ops:** 0 cycles of state; the path is purely combinational.
- **Misaligned ops:** ADDR_ERR is combinational, in the same cycle as the op.

## Test plan
- **LW, zero-wait:** LSADDR=0x100, RDATA=0xDEADBEEF with ACK in REQ → DRAM_ADDR=0x100, BE=1111, WE=0; STALL_REQ=1 for 2 cycles; WB_WDATA=0xDEADBEEF with WB_WEN=1 in DONE.
- **LB/LBU lanes:** LSADDR=0x103, RDATA=0x80FF_1234 → LB gives 0xFFFFFF80, LBU gives 0x00000080; BE=1000.
- **SH with 3 wait states:** LSADDR=0x202, SDATA=0x0000ABCD → DRAM_ADDR=0x200, BE=1100, WDATA=0xABCDABCD, WE=1; REQ held 4 cycles, outputs stable; STALL_REQ=1 for 5 cycles.
- **Misaligned LW:** LSADDR=0x101 → ADDR_ERR=1, DRAM_REQ stays 0, STALL_REQ=0, WB_WEN=0.
- **DONE with STALL_MEM=1 for 2 cycles:** FSM stays in DONE with no second request; it returns to IDLE after STALL_MEM falls.
- **Reset in REQ:** pull RST low → DRAM_REQ=0 immediately (asynchronously); after release the FSM is in IDLE and an ACK pulse has no effect.
